// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction buffer between fetch and decode.
// Entries are {pc, inst, fault}; the head is presented combinationally from
// storage (first-word fall-through) and gated to zero while the queue is empty.
// A synchronous flush empties the queue on a control-flow redirect.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_inst,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_inst,
  output logic                       out_fault,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(DEPTH - 1);

  // Entry storage, split per field so each array has a natural width.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] inst_mem  [DEPTH];
  logic            fault_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // Ready depends only on occupancy, so there is no out_ready -> in_ready path.
  assign in_ready  = !full;
  assign out_valid = !empty;

  // Flush wins over both transfers; the same-cycle input and head are untouched.
  assign push = in_valid && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write on push; the misalignment flag is computed once at entry time.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; an entry is only ever read after a push has
    // written it, because the output is gated whenever count is zero.
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      inst_mem[wr_ptr_q]  <= in_inst;
      fault_mem[wr_ptr_q] <= (in_pc[1:0] != 2'b00);
    end
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    out_pc    = '0;
    out_inst  = '0;
    out_fault = 1'b0;
    if (!empty) begin
      out_pc    = pc_mem[rd_ptr_q];
      out_inst  = inst_mem[rd_ptr_q];
      out_fault = fault_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=4). Inputs change and outputs
// are sampled 1ns after the rising edge; expected values are hand-computed.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [ILEN-1:0] in_inst;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;
  logic            out_fault;
  logic [2:0]      count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_fault (out_fault),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    tick();
    in_valid = 1'b0;
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] head_pc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);

    // 1. Reset mid-stream with three entries held, fetch still pushing.
    push_one(64'h200, 32'hA0);
    push_one(64'h204, 32'hA1);
    push_one(64'h208, 32'hA2);
    check("t1_count3", count, 3);
    in_valid = 1'b1;
    in_pc    = 64'h20C;
    #2;
    reset = 1'b1;
    #1;
    check("t1_async_count", count, 0);
    tick();
    in_valid = 1'b0;
    check("t1_count", count, 0);
    check("t1_out_valid", out_valid, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_out_pc", out_pc, 0);
    reset = 1'b0;
    tick();

    // 2. Fill to DEPTH with decode stalled; a fifth push is ignored.
    for (int i = 0; i < DEPTH; i++) begin
      push_one(64'(i * 4), 32'(32'h1000 + i));
    end
    check("t2_count_full", count, 4);
    check("t2_in_ready", in_ready, 0);
    check("t2_head_pc", out_pc, 64'h0);
    push_one(64'h10, 32'hDEAD);
    check("t2_overflow_count", count, 4);
    check("t2_overflow_head", out_pc, 64'h0);

    // 3. Drain from full. First drain cycle also offers a push: no push when
    //    full even with a simultaneous pop.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 64'h10;
    in_inst   = 32'hDEAD;
    for (int i = 0; i < DEPTH; i++) begin
      check("t3_out_valid", out_valid, 1);
      check("t3_out_pc", out_pc, 64'(i * 4));
      check("t3_out_inst", out_inst, 64'(32'h1000 + i));
      tick();
      in_valid = 1'b0;
      if (i == 0) check("t3_full_pop_no_push", count, 3);
    end
    check("t3_empty_valid", out_valid, 0);
    check("t3_empty_count", count, 0);
    check("t3_empty_pc", out_pc, 0);
    tick();
    check("t3_pop_empty_ignored", count, 0);
    out_ready = 1'b0;

    // 4. Steady streaming at count=2 across pointer wrap.
    push_one(64'h300, 32'h300);
    push_one(64'h304, 32'h304);
    next_pc = 64'h308;
    head_pc = 64'h300;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc   = next_pc;
      in_inst = next_pc[31:0];
      check("t4_stream_pc", out_pc, head_pc);
      tick();
      check("t4_stream_count", count, 2);
      next_pc = next_pc + 64'h4;
      head_pc = head_pc + 64'h4;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t4_drain_pc", out_pc, head_pc);
      check("t4_drain_inst", out_inst, {32'h0, head_pc[31:0]});
      tick();
      head_pc = head_pc + 64'h4;
    end
    check("t4_drained", count, 0);
    out_ready = 1'b0;

    // 5. Flush with simultaneous push and pop at count=3.
    push_one(64'h400, 32'h1);
    push_one(64'h404, 32'h2);
    push_one(64'h408, 32'h3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 64'h40;
    in_inst   = 32'h40;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t5_count", count, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    push_one(64'h50, 32'h50);
    check("t5_after_count", count, 1);
    check("t5_after_pc", out_pc, 64'h50);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_after_empty", count, 0);

    // 6. Misaligned PC raises fault; the following aligned entry does not.
    push_one(64'h102, 32'h00000013);
    check("t6_fault", out_fault, 1);
    check("t6_pc", out_pc, 64'h102);
    check("t6_inst", out_inst, 64'h13);
    in_valid  = 1'b1;
    in_pc     = 64'h104;
    in_inst   = 32'h00000093;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t6_next_count", count, 1);
    check("t6_next_pc", out_pc, 64'h104);
    check("t6_next_fault", out_fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
